// File: rtl/bnn_window_gen_pkg.sv
// Shared definitions for the binary window generator: FSM state encoding
// and the window / PE operand widths.
package bnn_pkg;
  typedef enum logic {
    S_FILL = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  localparam int WIN_W = 3;
  localparam int PE_W  = 9;
endpackage

// File: rtl/bnn_window_gen_if.sv
// Pixel-in / window-out handshake bundle. master drives pixels and consumes
// windows, slave is the window generator.
interface bnn_window_gen_if;
  import bnn_pkg::*;

  logic             in_pix;
  logic             in_valid;
  logic             in_ready;
  logic [WIN_W-1:0] win_a;
  logic [WIN_W-1:0] win_b;
  logic [WIN_W-1:0] win_c;
  logic             out_valid;
  logic             out_ready;
  logic             frame_done;

  modport master (
    output in_pix, in_valid, out_ready,
    input  in_ready, win_a, win_b, win_c, out_valid, frame_done
  );

  modport slave (
    input  in_pix, in_valid, out_ready,
    output in_ready, win_a, win_b, win_c, out_valid, frame_done
  );
endinterface

// File: rtl/bnn_window_gen_line_buf.sv
// One image row of delay: a W-bit shift register. dout is the bit that
// entered W enabled shifts ago, i.e. the same column one row earlier.
module bnn_line_buf
  import bnn_pkg::*;
#(
  parameter int W = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic din,
  output logic dout
);
  logic [W-1:0] sr;

  // Shift one position per accepted pixel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  sr <= '0;
    else if (en) sr <= {sr[W-2:0], din};
  end

  assign dout = sr[W-1];
endmodule

// File: rtl/bnn_window_gen.sv
// 3x3 sliding window generator for a binary image streamed in raster order.
// Two line buffers supply the two previous rows; a 3x3 register window
// shifts left one column per accepted pixel. Only fully interior windows
// (row>=2, col>=2) are emitted.
// Optional: define BNN_WIN_FRAME_CNT_EN to add an 8-bit completed-frame
// counter output frame_cnt.
module bnn_window_gen
  import bnn_pkg::*;
#(
  parameter int IMG_W = 8,
  parameter int IMG_H = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  bnn_window_gen_if.slave   bus
`ifdef BNN_WIN_FRAME_CNT_EN
  ,
  output logic [7:0]        frame_cnt
`endif
);
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

  state_t           state;
  logic [CW-1:0]    col;
  logic [RW-1:0]    row;
  logic [WIN_W-1:0] win_a, win_b, win_c;
  logic             out_valid, frame_done;
  logic             accept, consume;
  logic             lb1_out, lb2_out;

  assign bus.in_ready   = !out_valid || bus.out_ready;
  assign accept         = bus.in_valid && bus.in_ready;
  assign consume        = out_valid && bus.out_ready;
  assign bus.win_a      = win_a;
  assign bus.win_b      = win_b;
  assign bus.win_c      = win_c;
  assign bus.out_valid  = out_valid;
  assign bus.frame_done = frame_done;

  // lb1 delays the input by one row, lb2 chains off it for two rows.
  bnn_line_buf #(.W(IMG_W)) u_lb1 (
    .clk(clk), .rst_n(rst_n), .en(accept), .din(bus.in_pix), .dout(lb1_out)
  );
  bnn_line_buf #(.W(IMG_W)) u_lb2 (
    .clk(clk), .rst_n(rst_n), .en(accept), .din(lb1_out), .dout(lb2_out)
  );

  // Raster position, fill/run FSM, window shift and registered outputs.
  // Everything advances only on an accepted pixel, so the outputs are
  // naturally frozen while a window is stalled (in_ready is low then).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_FILL;
      col        <= '0;
      row        <= '0;
      win_a      <= '0;
      win_b      <= '0;
      win_c      <= '0;
      out_valid  <= 1'b0;
      frame_done <= 1'b0;
    end else if (accept) begin
      win_a      <= {lb2_out,    win_a[WIN_W-1:1]};
      win_b      <= {lb1_out,    win_b[WIN_W-1:1]};
      win_c      <= {bus.in_pix, win_c[WIN_W-1:1]};
      // Columns 0/1 would straddle the row wrap, so they are suppressed.
      out_valid  <= (state == S_RUN) && (col >= CW'(2));
      frame_done <= (state == S_RUN) && (col == COL_LAST) && (row == ROW_LAST);
      if (col == COL_LAST) begin
        col <= '0;
        row <= (row == ROW_LAST) ? '0 : row + RW'(1);
        case (state)
          S_FILL: if (row == RW'(1)) state <= S_RUN;
          S_RUN:  if (row == ROW_LAST) state <= S_FILL;
          default: state <= S_FILL;
        endcase
      end else begin
        col <= col + CW'(1);
      end
    end else if (consume) begin
      out_valid  <= 1'b0;
      frame_done <= 1'b0;
    end
  end

`ifdef BNN_WIN_FRAME_CNT_EN
  // Count frames whose final window has been taken downstream.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                    frame_cnt <= '0;
    else if (consume && frame_done) frame_cnt <= frame_cnt + 8'd1;
  end
`endif
endmodule

// File: doc/bnn_window_gen.md
BNN_WINDOW_GEN -- requirements
Module: bnn_window_gen

Interface
REQ-001 Parameter IMG_W, default 8: image width in pixels; legal range 3..256.
REQ-002 Parameter IMG_H, default 8: image height in pixels; legal range 3..256.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 in_pix  input  1  binary pixel, raster order (row-major, left to right).
REQ-006 in_valid  input  1  in_pix is valid this cycle.
REQ-007 in_ready  output  1  block accepts in_pix this cycle.
REQ-008 win_a  output  3  top window row; bit0 = leftmost column, bit2 = rightmost column.
REQ-009 win_b  output  3  middle window row; same bit order as win_a.
REQ-010 win_c  output  3  bottom window row; same bit order; {win_c,win_b,win_a} forms the 9-bit XNOR-popcount PE operand.
REQ-011 out_valid  output  1  window outputs are valid.
REQ-012 out_ready  input  1  downstream PE stage consumes the window.
REQ-013 frame_done  output  1  high together with the last window of a frame.

Function
REQ-014 The pixel handshake SHALL be: in_ready = !out_valid || out_ready; a pixel is accepted when in_valid && in_ready.
REQ-015 The window handshake SHALL be: a window is consumed when out_valid && out_ready; win_*, out_valid and frame_done SHALL hold stable while out_valid && !out_ready.
REQ-016 Column counter col (0..IMG_W-1) SHALL advance on each accepted pixel; it wraps to 0 after IMG_W-1 and advances row (0..IMG_H-1).
REQ-017 Row SHALL wrap to 0 after the last pixel of the frame; the next frame SHALL start with no idle cycle.
REQ-018 Two IMG_W-bit line buffers SHALL hold the previous two rows; one 3x3 shift window SHALL shift left one column per accepted pixel.
REQ-019 Per accepted pixel, the new column shifted into bit2 of win_a/win_b/win_c SHALL be {row-2 pixel, row-1 pixel, in_pix} at the same col.
REQ-020 An accepted pixel with row>=2 and col>=2 SHALL set out_valid on the next edge (latency 1 cycle); otherwise out_valid SHALL clear on that edge if the current window is consumed.
REQ-021 A frame SHALL produce exactly (IMG_W-2)*(IMG_H-2) windows; the window straddling a row wrap (col<2) SHALL NOT be emitted.
REQ-022 FSM state S_FILL (row<2): line buffers fill and no windows are emitted; S_FILL -> S_RUN on acceptance of the pixel at col IMG_W-1, row 1.
REQ-023 FSM state S_RUN: windows are emitted; S_RUN -> S_FILL on acceptance of the pixel at col IMG_W-1, row IMG_H-1.
REQ-024 frame_done SHALL be 1 exactly with the window generated from pixel (IMG_W-1, IMG_H-1), and 0 otherwise.
REQ-025 A pixel accepted in the same cycle that the current window is consumed SHALL be processed normally, with no bubble.

Reset
REQ-026 While rst_n is low: out_valid=0, frame_done=0, win_a=win_b=win_c=0, col=0, row=0, state=S_FILL, line buffers=0; in_ready=1 (this follows from REQ-014).
REQ-027 Reset asserted mid-frame SHALL discard the partial frame; the first pixel accepted after release is pixel (0,0).

Configuration
REQ-028 With BNN_WIN_FRAME_CNT_EN defined, output frame_cnt [7:0] SHALL exist and reset to 0.
REQ-029 With BNN_WIN_FRAME_CNT_EN defined, frame_cnt SHALL increment (wrapping at 255) when the window with frame_done=1 is consumed.
REQ-030 Without BNN_WIN_FRAME_CNT_EN defined, the frame_cnt port and its counter SHALL be absent and all other behaviour SHALL be unchanged.

Structure
REQ-031 Shared package bnn_pkg SHALL hold the FSM state encoding (S_FILL, S_RUN), the window row width constant (3) and the PE operand width constant (9).
REQ-032 One sub-module, bnn_line_buf, SHALL implement a single IMG_W-bit shift line buffer with shift enable and async active-low reset; it is instantiated twice.

Verification
REQ-033 Default 8x8 all-ones image, out_ready=1: 36 windows, each win_a=win_b=win_c=3'b111; frame_done high only on the 36th window.
REQ-034 Single 1 at pixel (0,0), rest 0: first window win_a=3'b001, win_b=win_c=0; the remaining 35 windows are all zero.
REQ-035 out_ready held 0 for 5 cycles while the 3rd window is valid: outputs stable, in_ready=0, no pixel lost; 36 windows in total, in order.
REQ-036 rst_n pulsed low after 20 accepted pixels, then a full all-ones frame sent: exactly 36 windows, no stale zeros from the aborted frame.
REQ-037 Two back-to-back frames with in_valid always 1 and out_ready=1: 72 windows, frame_done on windows 36 and 72, frame_cnt=2 when BNN_WIN_FRAME_CNT_EN is defined.
REQ-038 Random in_valid/out_ready (50%) on a random 8x8 image: every window equals the reference-model 3x3 extract.
